keypad_scan_ctrl: RTL and testbench
===================================

// Module: keypad_scan_ctrl
// PURPOSE
//  Scan sequencer for the 4x4 matrix keypad (active-low rows, pulled-up active-low cols).
//  Drives one row low at a time, waits a settle time, samples the columns and
//  debounces the full 16-key snapshot. Emits press/release events through a small
//  event FIFO with a valid/ready handshake, for the Pong paddle/menu logic.
// PARAMETERS
//  SETTLE_CYCLES   512  cycles waited after a row change before sampling (>=1)
//  DEBOUNCE_SCANS  4    consecutive identical full scans needed to accept a change (>=1)
//  FIFO_DEPTH      4    event FIFO entries (power of 2, >=2)
// PORTS
//  clk       in   1  system clock, all logic on rising edge
//  rst       in   1  synchronous, active-high reset
//  cols      in   4  column inputs, 0 = key closed on the driven row; cols[c] = column c
//  rows      out  4  row drive, active-low one-hot; 4'b1111 = no row driven
//  ev_valid  out  1  FIFO head holds an event
//  ev_ready  in   1  consumer accepts head; pop when ev_valid && ev_ready
//  ev_code   out  4  key code of head event
//  ev_press  out  1  1 = press, 0 = release
//  key_down  out  1  1 while any debounced key is held
//  overflow  out  1  sticky: an event was dropped (FIFO full); cleared only by rst
// BEHAVIOUR
//  Reset: rows=4'b1111, ev_valid=0, ev_code=0, ev_press=0, key_down=0, overflow=0;
//   row_idx=0, snapshot/candidate/debounced=0, stable_cnt=0, FIFO empty, state=DRIVE.
//  Key index k=4*row+col. Code map, row 0..3: {1,2,3,A} {4,5,6,B} {7,8,9,C} {E(*),0,F(#),D}.
//  FSM:
//   DRIVE  (1 cyc): rows <= ~(4'b0001<<row_idx); settle counter loaded -> SETTLE.
//   SETTLE (SETTLE_CYCLES cyc): count down -> SAMPLE.
//   SAMPLE (1 cyc): snapshot[4*row_idx+:4] <= ~cols; row_idx==3 ? (row_idx<=0, EVAL)
//          : (row_idx++, DRIVE).
//   EVAL   (1 cyc): snapshot!=candidate -> candidate<=snapshot, stable_cnt<=0, DRIVE.
//          Equal -> stable_cnt++ (saturating at DEBOUNCE_SCANS-1). If stable_cnt
//          (after update) == DEBOUNCE_SCANS-1 and candidate!=debounced -> EMIT, bit_idx=0;
//          else DRIVE.
//   EMIT   (16 cyc): per cycle, if candidate[bit_idx]!=debounced[bit_idx]: push
//          {code(bit_idx), candidate[bit_idx]}, debounced[bit_idx]<=candidate[bit_idx].
//          bit_idx 15 -> DRIVE. Events ordered by ascending k.
//  rows hold last driven value through SETTLE/SAMPLE/EVAL/EMIT.
//  Scan period (no EMIT) = 4*(SETTLE_CYCLES+2)+1 cycles.
//  key_down = |debounced, registered (updates the cycle after the debounced bit change).
//  FIFO: show-ahead; ev_code/ev_press valid whenever ev_valid=1, stable until popped.
//   Pop and push same cycle when full: pop first, push accepted, no overflow.
//   Push when full without pop: event dropped, overflow<=1, debounced still updated.
//   ev_valid rises the cycle after the first push into an empty FIFO.
//  Multiple keys: each changed bit reported independently; ghosting not resolved.
//  rst mid-operation (any state, incl. EMIT): everything returns to reset values;
//   keys still held afterwards are reported as fresh presses after debounce.
// TESTING (bench: SETTLE_CYCLES=4, DEBOUNCE_SCANS=2, FIFO_DEPTH=4; period 25 cyc)
//  1. Reset, no keys -> rows cycle 1110,1101,1011,0111, 6 cyc each; ev_valid stays 0.
//  2. Hold '5' (cols[1]=0 while rows[1]=0) -> one event code=5 press=1, key_down=1;
//     release -> code=5 press=0, key_down=0; no other events.
//  3. '5' toggled every scan for 10 scans -> no events, key_down=0.
//  4. '2' and '8' pressed in same scan -> events code=2 press=1 then code=8 press=1.
//  5. ev_ready=0, press keys 1,2,3,A,4 (one per stable window) -> 4 events held
//     (1,2,3,A), overflow=1; ev_ready=1 -> pops 1,2,3,A in order, ev_valid then 0.
//  6. Hold '0', assert rst during EMIT -> rows=1111, ev_valid=0, overflow=0 next cycle;
//     after release of rst, code=0 press=1 reported again.

Source files
------------

// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: drives one active-low row at a time, samples the
// columns, debounces the full 16-key snapshot and queues press/release events.
module keypad_scan_ctrl #(
  parameter int SETTLE_CYCLES  = 512,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] cols,
  output logic [3:0] rows,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [3:0] ev_code,
  output logic       ev_press,
  output logic       key_down,
  output logic       overflow
);
  // state  | meaning
  // DRIVE  | drive next row low, load settle timer
  // SETTLE | wait for column lines to settle
  // SAMPLE | capture inverted columns for the driven row
  // EVAL   | compare full snapshot against candidate, run debounce count
  // EMIT   | walk all 16 keys, queue an event for every changed bit
  typedef enum logic [2:0] {S_DRIVE, S_SETTLE, S_SAMPLE, S_EVAL, S_EMIT} state_t;

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int DW = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
  localparam logic [DW-1:0] STABLE_MAX  = DW'(DEBOUNCE_SCANS - 1);
  localparam logic [AW:0]   FIFO_FULL   = (AW+1)'(FIFO_DEPTH);

  state_t         state_q, state_d;
  logic [SW-1:0]  settle_cnt_q;
  logic [1:0]     row_idx_q;
  logic [3:0]     bit_idx_q;
  logic [DW-1:0]  stable_cnt_q, stable_inc;
  logic [15:0]    snapshot_q, candidate_q, debounced_q;
  logic [3:0]     rows_q;
  logic           key_down_q, overflow_q;
  logic [4:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [AW:0]    count_q;
  logic           snap_eq, push, pop, full, accept;
  logic [4:0]     push_data;

  function automatic logic [3:0] key_code(input logic [3:0] k);
    case (k)
      4'd0:  key_code = 4'h1;  4'd1:  key_code = 4'h2;
      4'd2:  key_code = 4'h3;  4'd3:  key_code = 4'hA;
      4'd4:  key_code = 4'h4;  4'd5:  key_code = 4'h5;
      4'd6:  key_code = 4'h6;  4'd7:  key_code = 4'hB;
      4'd8:  key_code = 4'h7;  4'd9:  key_code = 4'h8;
      4'd10: key_code = 4'h9;  4'd11: key_code = 4'hC;
      4'd12: key_code = 4'hE;  4'd13: key_code = 4'h0;
      4'd14: key_code = 4'hF;  default: key_code = 4'hD;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_DRIVE;
    else     state_q <= state_d;
  end

  always_comb begin
    snap_eq    = (snapshot_q == candidate_q);
    stable_inc = (stable_cnt_q == STABLE_MAX) ? stable_cnt_q : stable_cnt_q + 1'b1;
    state_d    = state_q;
    case (state_q)
      S_DRIVE:  state_d = S_SETTLE;
      S_SETTLE: if (settle_cnt_q == '0) state_d = S_SAMPLE;
      S_SAMPLE: state_d = (row_idx_q == 2'd3) ? S_EVAL : S_DRIVE;
      S_EVAL:   state_d = (snap_eq && stable_inc == STABLE_MAX &&
                           candidate_q != debounced_q) ? S_EMIT : S_DRIVE;
      S_EMIT:   if (bit_idx_q == 4'd15) state_d = S_DRIVE;
      default:  state_d = S_DRIVE;
    endcase
  end

  always_comb begin
    push      = (state_q == S_EMIT) && (candidate_q[bit_idx_q] != debounced_q[bit_idx_q]);
    push_data = {key_code(bit_idx_q), candidate_q[bit_idx_q]};
    full      = (count_q == FIFO_FULL);
    pop       = (count_q != '0) && ev_ready;
    accept    = push && (!full || pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt_q <= '0;
      row_idx_q    <= '0;
      bit_idx_q    <= '0;
      stable_cnt_q <= '0;
      snapshot_q   <= '0;
      candidate_q  <= '0;
      debounced_q  <= '0;
      rows_q       <= 4'b1111;
      key_down_q   <= 1'b0;
    end else begin
      key_down_q <= |debounced_q;
      case (state_q)
        S_DRIVE: begin
          rows_q       <= ~(4'b0001 << row_idx_q);
          settle_cnt_q <= SETTLE_LOAD;
        end
        S_SETTLE: if (settle_cnt_q != '0) settle_cnt_q <= settle_cnt_q - 1'b1;
        S_SAMPLE: begin
          snapshot_q[{row_idx_q, 2'b00} +: 4] <= ~cols;
          row_idx_q <= row_idx_q + 2'd1;
        end
        S_EVAL: begin
          bit_idx_q <= '0;
          if (!snap_eq) begin
            candidate_q  <= snapshot_q;
            stable_cnt_q <= '0;
          end else begin
            stable_cnt_q <= stable_inc;
          end
        end
        S_EMIT: begin
          bit_idx_q <= bit_idx_q + 4'd1;
          // debounced follows the candidate even when the event itself is dropped
          if (push) debounced_q[bit_idx_q] <= candidate_q[bit_idx_q];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (accept) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (AW+1)'(accept) - (AW+1)'(pop);
      if (push && !accept) overflow_q <= 1'b1;
    end
  end

  assign rows     = rows_q;
  assign ev_valid = (count_q != '0);
  assign ev_code  = mem_q[rd_ptr_q][4:1];
  assign ev_press = mem_q[rd_ptr_q][0];
  assign key_down = key_down_q;
  assign overflow = overflow_q;
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with a behavioural 4x4 key matrix.
module tb_keypad_scan_ctrl;
  localparam int SETTLE = 4;
  localparam int DEB    = 2;
  localparam int DEPTH  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  cols;
  logic [3:0]  rows;
  logic        ev_valid, ev_ready, ev_press, key_down, overflow;
  logic [3:0]  ev_code;
  logic [15:0] keys;
  int          checks = 0;
  int          errors = 0;

  keypad_scan_ctrl #(.SETTLE_CYCLES(SETTLE), .DEBOUNCE_SCANS(DEB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .cols(cols), .rows(rows), .ev_valid(ev_valid),
    .ev_ready(ev_ready), .ev_code(ev_code), .ev_press(ev_press),
    .key_down(key_down), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // closed key pulls its column low while its row is driven low
  always_comb begin
    cols = 4'hF;
    for (int r = 0; r < 4; r++)
      if (rows[r] == 1'b0) cols = cols & ~keys[4*r +: 4];
  end

  task automatic get_event(output logic [3:0] code, output logic press);
    int n = 0;
    while (ev_valid !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (ev_valid !== 1'b1) begin
      checks++; errors++;
      $display("FAIL event_timeout: ev_valid=%b required 1", ev_valid);
      code = 4'hx; press = 1'bx;
    end else begin
      code = ev_code; press = ev_press;
      ev_ready = 1'b1;
      @(negedge clk);
      ev_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; keys = '0; ev_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (rows !== 4'b1111) begin errors++; $display("FAIL reset_rows: got %b want 1111", rows); end
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL reset_ev_valid: got %b want 0", ev_valid); end
    checks++; if (ev_code !== 4'h0) begin errors++; $display("FAIL reset_ev_code: got %h want 0", ev_code); end
    checks++; if (ev_press !== 1'b0) begin errors++; $display("FAIL reset_ev_press: got %b want 0", ev_press); end
    checks++; if (key_down !== 1'b0) begin errors++; $display("FAIL reset_key_down: got %b want 0", key_down); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    rst = 1'b0;
  endtask

  task automatic test_scan_idle;
    int bad = 0;
    int vseen = 0;
    logic [3:0] exp;
    logic [3:0] first_bad = 4'h0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      case (((i - 1) % 25) / 6)
        0: exp = 4'b1110;
        1: exp = 4'b1101;
        2: exp = 4'b1011;
        default: exp = 4'b0111;
      endcase
      if (rows !== exp) begin
        if (bad == 0) first_bad = rows;
        bad++;
      end
      if (ev_valid !== 1'b0) vseen++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL scan_rows: %0d wrong cycles, first value %b", bad, first_bad); end
    checks++; if (vseen != 0) begin errors++; $display("FAIL scan_idle_ev_valid: high %0d cycles want 0", vseen); end
  endtask

  task automatic test_single_key;
    logic [3:0] c; logic p; int vseen = 0;
    keys[5] = 1'b1;
    get_event(c, p);
    checks++; if (c !== 4'h5 || p !== 1'b1) begin errors++; $display("FAIL key5_press: got code=%h press=%b want 5/1", c, p); end
    repeat (2) @(negedge clk);
    checks++; if (key_down !== 1'b1) begin errors++; $display("FAIL key5_key_down: got %b want 1", key_down); end
    keys[5] = 1'b0;
    get_event(c, p);
    checks++; if (c !== 4'h5 || p !== 1'b0) begin errors++; $display("FAIL key5_release: got code=%h press=%b want 5/0", c, p); end
    repeat (2) @(negedge clk);
    checks++; if (key_down !== 1'b0) begin errors++; $display("FAIL key5_key_up: got %b want 0", key_down); end
    repeat (80) begin @(negedge clk); if (ev_valid !== 1'b0) vseen++; end
    checks++; if (vseen != 0) begin errors++; $display("FAIL key5_extra_events: ev_valid high %0d cycles want 0", vseen); end
  endtask

  task automatic test_bounce;
    int vseen = 0;
    for (int t = 0; t < 10; t++) begin
      keys[5] = ~keys[5];
      repeat (25) begin @(negedge clk); if (ev_valid !== 1'b0) vseen++; end
    end
    repeat (80) begin @(negedge clk); if (ev_valid !== 1'b0) vseen++; end
    checks++; if (vseen != 0) begin errors++; $display("FAIL bounce_events: ev_valid high %0d cycles want 0", vseen); end
    checks++; if (key_down !== 1'b0) begin errors++; $display("FAIL bounce_key_down: got %b want 0", key_down); end
  endtask

  task automatic test_two_keys;
    logic [3:0] c; logic p;
    keys[1] = 1'b1; keys[9] = 1'b1;
    get_event(c, p);
    checks++; if (c !== 4'h2 || p !== 1'b1) begin errors++; $display("FAIL two_first: got code=%h press=%b want 2/1", c, p); end
    get_event(c, p);
    checks++; if (c !== 4'h8 || p !== 1'b1) begin errors++; $display("FAIL two_second: got code=%h press=%b want 8/1", c, p); end
    keys[1] = 1'b0; keys[9] = 1'b0;
    get_event(c, p);
    checks++; if (c !== 4'h2 || p !== 1'b0) begin errors++; $display("FAIL two_rel_first: got code=%h press=%b want 2/0", c, p); end
    get_event(c, p);
    checks++; if (c !== 4'h8 || p !== 1'b0) begin errors++; $display("FAIL two_rel_second: got code=%h press=%b want 8/0", c, p); end
  endtask

  task automatic test_overflow;
    logic [3:0] c; logic p;
    logic [3:0] exp_code [4];
    exp_code[0] = 4'h1; exp_code[1] = 4'h2; exp_code[2] = 4'h3; exp_code[3] = 4'hA;
    ev_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      keys[k] = 1'b1;
      repeat (110) @(negedge clk);
    end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_full_no_drop: overflow=%b want 0", overflow); end
    checks++; if (ev_valid !== 1'b1) begin errors++; $display("FAIL ovf_held_valid: ev_valid=%b want 1", ev_valid); end
    keys[4] = 1'b1;
    repeat (110) @(negedge clk);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: overflow=%b want 1", overflow); end
    for (int i = 0; i < 4; i++) begin
      get_event(c, p);
      checks++;
      if (c !== exp_code[i] || p !== 1'b1) begin
        errors++; $display("FAIL ovf_pop%0d: got code=%h press=%b want %h/1", i, c, p, exp_code[i]);
      end
    end
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained: ev_valid=%b want 0", ev_valid); end
    keys = '0;
    ev_ready = 1'b1;
    repeat (150) @(negedge clk);
    ev_ready = 1'b0;
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL ovf_release_drain: ev_valid=%b want 0", ev_valid); end
  endtask

  task automatic test_rst_mid_emit;
    logic [3:0] c; logic p; int n = 0;
    keys[13] = 1'b1;
    while (ev_valid !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    checks++; if (ev_valid !== 1'b1) begin errors++; $display("FAIL rst_emit_timeout: ev_valid=%b want 1", ev_valid); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL rst_pre_overflow: overflow=%b want 1", overflow); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (rows !== 4'b1111) begin errors++; $display("FAIL rst_mid_rows: got %b want 1111", rows); end
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_ev_valid: got %b want 0", ev_valid); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_mid_overflow: got %b want 0", overflow); end
    checks++; if (key_down !== 1'b0) begin errors++; $display("FAIL rst_mid_key_down: got %b want 0", key_down); end
    rst = 1'b0;
    get_event(c, p);
    checks++; if (c !== 4'h0 || p !== 1'b1) begin errors++; $display("FAIL rst_repress: got code=%h press=%b want 0/1", c, p); end
    repeat (2) @(negedge clk);
    checks++; if (key_down !== 1'b1) begin errors++; $display("FAIL rst_repress_key_down: got %b want 1", key_down); end
  endtask

  initial begin
    rst = 1'b1; keys = '0; ev_ready = 1'b0;
    test_reset();
    test_scan_idle();
    test_single_key();
    test_bounce();
    test_two_keys();
    test_overflow();
    test_rst_mid_emit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
